bsn_loader: RTL
===============

BSN_LOADER -- requirements
Module: bsn_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one key word.
REQ-002 Parameter N_INPUTS, default 8: words per sort frame; power of two, >=2.
REQ-003 Parameter SORT_LATENCY, default 6: enabled clock edges the downstream sorter needs to produce a result.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DATA_WIDTH  serial key word.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  word accepted when in_valid && in_ready at a clock edge.
REQ-009 in_last  input  1  marks the final word of a short frame; used only under BSN_LOADER_PAD_EN.
REQ-010 in_dir  input  1  sort direction, sampled with the first word of a frame.
REQ-011 bsn_data  output  N_INPUTS*DATA_WIDTH  packed frame to sorter data_in.
REQ-012 bsn_en  output  1  sorter enable.
REQ-013 bsn_dir  output  1  sorter direction.
REQ-014 bsn_result  input  N_INPUTS*DATA_WIDTH  sorter data_out.
REQ-015 result_data  output  N_INPUTS*DATA_WIDTH  sorted frame.
REQ-016 result_valid  output  1  result_data valid.
REQ-017 result_ready  input  1  consumer accepts result.

Function
REQ-018 States: FILL, RUN, DONE; the block SHALL enter FILL with slot count 0 on reset.
REQ-019 FILL: in_ready=1; each accepted word is written to slot k (bits (k+1)*DATA_WIDTH-1 : k*DATA_WIDTH) of bsn_data, k starting at 0; k increments by 1 per accepted word.
REQ-020 The first accepted word of a frame latches in_dir into bsn_dir; bsn_dir SHALL stay constant until the next frame's first word.
REQ-021 Accepting word N_INPUTS-1 moves FILL->RUN on that edge; k returns to 0.
REQ-022 RUN: in_ready=0, bsn_en=1, bsn_data held stable; a cycle counter counts 0..SORT_LATENCY-1; RUN->DONE after exactly SORT_LATENCY cycles.
REQ-023 DONE: bsn_en=0, in_ready=0, result_valid=1, result_data=bsn_result (pass-through; sorter frozen by bsn_en=0).
REQ-024 Latency: last word accepted at edge of cycle t -> result_valid first high in cycle t+SORT_LATENCY+1.
REQ-025 DONE with result_ready=1 at an edge -> FILL; in_valid in that same cycle SHALL NOT be accepted.
REQ-026 result_data SHALL be all-zero whenever result_valid=0.
REQ-027 bsn_en SHALL be 0 in FILL and DONE; no sorter edges are enabled outside RUN.
REQ-028 Counter widths SHALL be $clog2 of their ranges; no wrap beyond N_INPUTS-1 or SORT_LATENCY-1.

Reset
REQ-029 rst low at any time (including mid-FILL or mid-RUN) SHALL immediately force: state FILL, k=0, bsn_data=0, bsn_dir=0, bsn_en=0, in_ready=0 while rst low, result_valid=0, result_data=0; a partial frame is discarded.
REQ-030 in_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-031 Macro BSN_LOADER_PAD_EN defined: in_last=1 on an accepted word with k<N_INPUTS-1 fills slots k+1..N_INPUTS-1 with the pad value (all-ones if bsn_dir=1, all-zero if bsn_dir=0) and moves FILL->RUN on that edge.
REQ-032 Macro BSN_LOADER_PAD_EN undefined: in_last SHALL be ignored; every frame is exactly N_INPUTS words.

Verification
REQ-033 Default parameters, words 7,3,5,1,8,2,6,4, in_dir=0, in_valid continuous -> in_ready low for 7 cycles after last word, bsn_en high 6 cycles, result_valid in cycle t+7.
REQ-034 Back-to-back frames, result_ready held 1 -> result_valid high for exactly one cycle per frame; no word accepted during RUN/DONE.
REQ-035 result_ready held 0 for 10 cycles in DONE -> result_valid and result_data stable, bsn_en=0, in_ready=0 throughout.
REQ-036 rst pulsed low after 4 words and again on 3rd RUN cycle -> all outputs zero immediately; next full frame of 8 words processed normally.
REQ-037 PAD_EN build, 3 words 0x10,0x30,0x20 with in_last on third, in_dir=1 -> bsn_data slots 3..7 = 0xFFFFFFFF, RUN entered on third-word edge.
REQ-038 in_valid toggled 1/0 every cycle -> 8 words collected in 16 cycles, slots in arrival order.

Source files
------------

// File: rtl/bsn_loader.sv
// bsn_loader: serial-to-parallel frame loader wrapped around a
// fixed-latency sorter. Collects N_INPUTS key words, enables the
// sorter for SORT_LATENCY edges, then presents the sorted frame.
//
// Ports:
//   clk, rst (async, active low)
//   in_data/in_valid/in_ready/in_last/in_dir : serial key input
//   bsn_data/bsn_en/bsn_dir                  : drive to the sorter
//   bsn_result                               : sorter output
//   result_data/result_valid/result_ready    : sorted frame output
//
// Build option: define BSN_LOADER_PAD_EN to let in_last end a
// short frame; unused slots are filled with a pad value.
module bsn_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_INPUTS     = 8,
  parameter int SORT_LATENCY = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic                           in_dir,
  output logic [N_INPUTS*DATA_WIDTH-1:0] bsn_data,
  output logic                           bsn_en,
  output logic                           bsn_dir,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] bsn_result,
  output logic [N_INPUTS*DATA_WIDTH-1:0] result_data,
  output logic                           result_valid,
  input  logic                           result_ready
);

  localparam int KW = $clog2(N_INPUTS);
  localparam int CW =
    (SORT_LATENCY > 1) ? $clog2(SORT_LATENCY) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N_INPUTS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SORT_LATENCY - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  logic [N_INPUTS-1:0][DATA_WIDTH-1:0] data_q, data_d;

  logic accept;

`ifndef BSN_LOADER_PAD_EN
  // Short frames are not supported in this build.
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  // Ready is forced low for as long as reset is held.
  assign in_ready = rst && (state_q == S_FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          data_d[k_q] = in_data;
          if (k_q == '0) begin
            dir_d = in_dir;
          end
          if (k_q == K_LAST) begin
            state_d = S_RUN;
            k_d     = '0;
          end
`ifdef BSN_LOADER_PAD_EN
          else if (in_last) begin
            // Pad toward the end the sorter moves them to.
            for (int j = 0; j < N_INPUTS; j++) begin
              if (j > int'(k_q)) begin
                data_d[j] = {DATA_WIDTH{dir_d}};
              end
            end
            state_d = S_RUN;
            k_d     = '0;
          end
`endif
          else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Words offered in this cycle are not taken:
        // in_ready is low until the FILL cycle.
        if (result_ready) begin
          state_d = S_FILL;
        end
      end

      default: begin
        state_d = S_FILL;
        k_d     = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
      k_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  assign bsn_data     = data_q;
  assign bsn_dir      = dir_q;
  assign bsn_en       = (state_q == S_RUN);
  assign result_valid = (state_q == S_DONE);

  // Sorter is frozen outside RUN, so its output is
  // simply forwarded while the result is on offer.
  assign result_data  = result_valid ? bsn_result : '0;

endmodule
